// File: rtl/pwm_capture_pkg.sv
// Shared types and widths for the PWM capture monitor.
// On/off enables and the capture FSM state encoding live here so the top and the bench agree.
package pwm_capture_pkg;

  localparam int PWMCOUNT_WIDTH = 16;

  typedef enum logic {PWM_OFF = 1'b0, PWM_ON = 1'b1} _pwm_onoff;
  typedef enum logic {DT_OFF = 1'b0, DT_ON = 1'b1} _dt_onoff;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ARM  = 2'd1,
    CAP_HIGH = 2'd2,
    CAP_LOW  = 2'd3
  } _cap_state;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Output is the last stage; all stages clear on reset.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of PWM leg A, flags a stalled carrier,
// and latches a sticky fault when both legs are high at once.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int               CNT_W       = PWMCOUNT_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT     = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pwm_in_A,
  input  logic             pwm_in_B,
  input  _pwm_onoff        cap_en,
  input  _dt_onoff         dt_check,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             cap_valid,
  output logic             timeout,
  output logic             overlap_fault
);

  logic [1:0] raw_in;
  logic [1:0] sync_out;

  assign raw_in = {pwm_in_B, pwm_in_A};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .resetn(resetn),
      .d     (raw_in[gi]),
      .q     (sync_out[gi])
    );
  end

  logic a_s, b_s, a_q_reg;
  logic rise, fall;

  assign a_s  = sync_out[0];
  assign b_s  = sync_out[1];
  assign rise = a_s & ~a_q_reg;
  assign fall = ~a_s & a_q_reg;

  _cap_state        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hi_lat_reg, hi_lat_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             valid_reg, valid_next;
  logic             timeout_reg, timeout_next;
  logic             fault_reg, fault_next;
  logic             at_limit;
  logic [CNT_W-1:0] cnt_inc;

  // The limit check pre-empts the increment, so cnt can never pass TIMEOUT.
  assign at_limit = (cnt_reg >= TIMEOUT);
  assign cnt_inc  = cnt_reg + CNT_W'(1);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_lat_next  = hi_lat_reg;
    high_next    = high_reg;
    period_next  = period_reg;
    valid_next   = 1'b0;
    timeout_next = timeout_reg;

    if (cap_en != PWM_ON) begin
      state_next   = CAP_IDLE;
      cnt_next     = '0;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        CAP_IDLE: begin
          state_next = CAP_ARM;
          cnt_next   = '0;
        end
        CAP_ARM: begin
          if (rise) begin
            cnt_next     = CNT_W'(1);
            timeout_next = 1'b0;
            state_next   = CAP_HIGH;
          end
        end
        CAP_HIGH: begin
          if (at_limit) begin
            timeout_next = 1'b1;
            state_next   = CAP_ARM;
          end else begin
            cnt_next = cnt_inc;
            if (fall) begin
              hi_lat_next = cnt_reg;
              state_next  = CAP_LOW;
            end
          end
        end
        CAP_LOW: begin
          if (at_limit) begin
            timeout_next = 1'b1;
            state_next   = CAP_ARM;
          end else if (rise) begin
            period_next = cnt_reg;
            high_next   = hi_lat_reg;
            valid_next  = 1'b1;
            cnt_next    = CNT_W'(1);
            state_next  = CAP_HIGH;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: state_next = CAP_IDLE;
      endcase
    end
  end

  // A fresh overlap outranks a clear arriving in the same cycle.
  always_comb begin
    fault_next = fault_reg;
    if ((dt_check == DT_ON) && a_s && b_s) begin
      fault_next = 1'b1;
    end else if (fault_clr) begin
      fault_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q_reg     <= 1'b0;
      state_reg   <= CAP_IDLE;
      cnt_reg     <= '0;
      hi_lat_reg  <= '0;
      high_reg    <= '0;
      period_reg  <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      a_q_reg     <= a_s;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_lat_reg  <= hi_lat_next;
      high_reg    <= high_next;
      period_reg  <= period_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
      fault_reg   <= fault_next;
    end
  end

  assign high_cnt      = high_reg;
  assign period_cnt    = period_reg;
  assign cap_valid     = valid_reg;
  assign timeout       = timeout_reg;
  assign overlap_fault = fault_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a timestamp-based reference model.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int S   = 2;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        pwm_a = 1'b0;
  logic        pwm_b = 1'b1;
  _pwm_onoff   cap_en = PWM_OFF;
  _dt_onoff    dt_check = DT_ON;
  logic        fault_clr = 1'b0;
  logic [15:0] high_cnt, period_cnt;
  logic        cap_valid, timeout, overlap_fault;

  int total = 0;
  int bad = 0;
  int valid_seen = 0;

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(S), .TIMEOUT(16'(TMO))) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pwm_in_A     (pwm_a),
    .pwm_in_B     (pwm_b),
    .cap_en       (cap_en),
    .dt_check     (dt_check),
    .fault_clr    (fault_clr),
    .high_cnt     (high_cnt),
    .period_cnt   (period_cnt),
    .cap_valid    (cap_valid),
    .timeout      (timeout),
    .overlap_fault(overlap_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works on timestamps of edges of the input streams delayed by the
  // synchronizer depth, computing measurements as differences between edge times.
  logic        ha [0:S+1];
  logic        hb [0:S+1];
  int          cyc = 0;
  int          last_rise = 0;
  int          last_fall = 0;
  bit          have_rise = 0;
  bit          en_prev = 0;
  logic        m_valid = 0, m_to = 0, m_ovl = 0;
  logic [15:0] m_high = 0, m_period = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (!resetn) begin
        for (int i = 0; i <= S + 1; i++) begin ha[i] = 1'b0; hb[i] = 1'b0; end
        have_rise = 0; en_prev = 0;
        m_valid = 0; m_to = 0; m_ovl = 0; m_high = 0; m_period = 0;
      end else begin
        logic da, dp, db, r, f;
        for (int i = S + 1; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
        ha[0] = pwm_a; hb[0] = pwm_b;
        da = ha[S]; dp = ha[S+1]; db = hb[S];
        r = da & ~dp;
        f = ~da & dp;
        m_valid = 1'b0;
        if (dt_check == DT_ON && da && db) m_ovl = 1'b1;
        else if (fault_clr) m_ovl = 1'b0;
        if (cap_en != PWM_ON) begin
          have_rise = 0; en_prev = 0; m_to = 1'b0;
        end else begin
          if (en_prev) begin
            if (have_rise && (cyc - last_rise) >= TMO) begin
              m_to = 1'b1; have_rise = 0;
            end else if (r) begin
              if (have_rise) begin
                m_period = 16'(cyc - last_rise);
                m_high   = 16'(last_fall - last_rise);
                m_valid  = 1'b1;
              end
              have_rise = 1; last_rise = cyc; m_to = 1'b0;
            end else if (f && have_rise) begin
              last_fall = cyc;
            end
          end
          en_prev = 1;
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        check("rst_valid", {31'd0, cap_valid}, 0);
        check("rst_high", {16'd0, high_cnt}, 0);
        check("rst_period", {16'd0, period_cnt}, 0);
        check("rst_timeout", {31'd0, timeout}, 0);
        check("rst_fault", {31'd0, overlap_fault}, 0);
      end else begin
        check("cap_valid", {31'd0, cap_valid}, {31'd0, m_valid});
        check("high_cnt", {16'd0, high_cnt}, {16'd0, m_high});
        check("period_cnt", {16'd0, period_cnt}, {16'd0, m_period});
        check("timeout", {31'd0, timeout}, {31'd0, m_to});
        check("overlap_fault", {31'd0, overlap_fault}, {31'd0, m_ovl});
      end
      if (cap_valid === 1'b1) begin
        valid_seen++;
        $display("capture: high_cnt=%0d period_cnt=%0d t=%0t", high_cnt, period_cnt, $time);
      end
    end
  end

  task automatic step(input logic a, input logic b, input logic clr);
    @(posedge clk);
    #1;
    pwm_a = a; pwm_b = b; fault_clr = clr;
  endtask

  task automatic periods(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < hi; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    int v0, first_to, hi, lo;
    logic ov;
    #2 resetn = 1'b0;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    resetn = 1'b1;
    cap_en = PWM_ON;
    #1;
    check("reset_high", {16'd0, high_cnt}, 0);
    check("reset_timeout", {31'd0, timeout}, 0);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Sawtooth 0..99 compared against 30 gives a 30/100 carrier, five periods.
    v0 = valid_seen;
    for (int i = 0; i < 500; i++) begin
      logic a;
      a = ((i % 100) < 30);
      step(a, ~a, 1'b0);
    end
    repeat (5) step(1'b0, 1'b1, 1'b0);
    check("t1_pulses", valid_seen - v0, 4);
    check("t1_high", {16'd0, high_cnt}, 30);
    check("t1_period", {16'd0, period_cnt}, 100);
    check("t1_fault", {31'd0, overlap_fault}, 0);

    // Stalled carrier after one rise.
    first_to = 0;
    for (int n = 1; n <= 260; n++) begin
      step(n <= 30, n > 30, 1'b0);
      if (timeout === 1'b1 && first_to == 0) first_to = n;
    end
    check("t3_timeout_cycle", first_to, S + 2 + TMO);
    v0 = valid_seen;
    periods(30, 70, 2);
    check("t3_pulses", valid_seen - v0, 1);
    check("t3_timeout_clr", {31'd0, timeout}, 0);
    check("t3_period", {16'd0, period_cnt}, 100);

    // Disable mid-HIGH, then re-enable.
    repeat (10) step(1'b1, 1'b0, 1'b0);
    cap_en = PWM_OFF;
    v0 = valid_seen;
    repeat (10) step(1'b1, 1'b0, 1'b0);
    periods(20, 50, 2);
    check("t5_off_pulses", valid_seen - v0, 0);
    check("t5_hold_high", {16'd0, high_cnt}, 30);
    check("t5_hold_period", {16'd0, period_cnt}, 100);
    cap_en = PWM_ON;
    v0 = valid_seen;
    repeat (10) step(1'b0, 1'b1, 1'b0);
    periods(20, 50, 3);
    check("t5_on_pulses", valid_seen - v0, 2);
    check("t5_high", {16'd0, high_cnt}, 20);
    check("t5_period", {16'd0, period_cnt}, 70);

    // Overlap fault: set, clear, DT_OFF ignored, set wins over clear.
    dt_check = DT_ON;
    step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    check("t4_set", {31'd0, overlap_fault}, 1);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    check("t4_clr", {31'd0, overlap_fault}, 0);
    dt_check = DT_OFF;
    step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    check("t4_dt_off", {31'd0, overlap_fault}, 0);
    dt_check = DT_ON;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    check("t4_set_wins", {31'd0, overlap_fault}, 1);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-LOW, then two rises before the first publish.
    periods(20, 50, 2);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0);
    resetn = 1'b0;
    #1;
    check("t6_high_zero", {16'd0, high_cnt}, 0);
    check("t6_period_zero", {16'd0, period_cnt}, 0);
    check("t6_valid_zero", {31'd0, cap_valid}, 0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    resetn = 1'b1;
    v0 = valid_seen;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    periods(20, 50, 2);
    check("t6_pulses", valid_seen - v0, 1);
    check("t6_high", {16'd0, high_cnt}, 20);
    check("t6_period", {16'd0, period_cnt}, 70);

    // Randomized carrier, dead time, overlaps, clears, enables and stalls.
    for (int k = 0; k < 60; k++) begin
      hi = $urandom_range(1, 40);
      lo = $urandom_range(1, 40);
      if ($urandom_range(0, 19) == 0) lo = $urandom_range(150, 260);
      dt_check = ($urandom_range(0, 3) != 0) ? DT_ON : DT_OFF;
      if ($urandom_range(0, 11) == 0) cap_en = (cap_en == PWM_ON) ? PWM_OFF : PWM_ON;
      ov = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < hi; i++)
        step(1'b1, ov && (i == 0), $urandom_range(0, 15) == 0);
      for (int i = 0; i < lo; i++)
        step(1'b0, (i > 0) && (i < lo - 1), $urandom_range(0, 15) == 0);
    end
    repeat (5) step(1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
